// File: rtl/conv_operand_loader.sv
// Operand loader for single_process_array: assembles a 25-beat frame (a11..a44, b11..b33)
// from a valid/ready byte stream, launches the array and waits for done. Optional RUN watchdog: LOADER_TIMEOUT_EN.
//
// state | meaning
// LOAD  | accepting frame beats, writing operand[cnt]
// RUN   | operands frozen, active_single high, waiting for done_single
// DRAIN | frame overran 25 beats; discarding beats until in_last
module conv_operand_loader #(
    parameter int DATA_W         = 8,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    input  logic              done_single,
    output logic              active_single,
    output logic [DATA_W-1:0] a11, a12, a13, a14,
    output logic [DATA_W-1:0] a21, a22, a23, a24,
    output logic [DATA_W-1:0] a31, a32, a33, a34,
    output logic [DATA_W-1:0] a41, a42, a43, a44,
    output logic [DATA_W-1:0] b11, b12, b13,
    output logic [DATA_W-1:0] b21, b22, b23,
    output logic [DATA_W-1:0] b31, b32, b33,
    output logic              frame_err,
    output logic [7:0]        frames_done
);

    typedef enum logic [1:0] {LOAD, RUN, DRAIN} state_t;

    localparam logic [4:0] LAST_BEAT = 5'd24;

    state_t            state;
    logic [4:0]        cnt;
    logic [DATA_W-1:0] ops [25];
    logic              ready_en;
    logic              fire;

    // ready_en holds in_ready low throughout reset while keeping it a function of registered state
    assign in_ready = ready_en && (state != RUN);
    assign fire     = in_valid && in_ready;

`ifdef LOADER_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT_CYCLES - 1);
    logic [TMR_W-1:0] tmr;
`else
    // Watchdog absent in this build; the parameter stays referenced so both builds share one interface.
    if (TIMEOUT_CYCLES < 0) begin : g_no_timeout
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= LOAD;
            cnt           <= '0;
            ready_en      <= 1'b0;
            active_single <= 1'b0;
            frame_err     <= 1'b0;
            frames_done   <= '0;
            for (int i = 0; i < 25; i++) ops[i] <= '0;
`ifdef LOADER_TIMEOUT_EN
            tmr           <= '0;
`endif
        end else begin
            ready_en <= 1'b1;
            case (state)
                LOAD: begin
                    if (fire) begin
                        ops[cnt] <= in_data;
                        if (cnt == LAST_BEAT) begin
                            cnt <= '0;
                            if (in_last) begin
                                state         <= RUN;
                                active_single <= 1'b1;
`ifdef LOADER_TIMEOUT_EN
                                tmr           <= TMR_LOAD;
`endif
                            end else begin
                                frame_err <= 1'b1;
                                state     <= DRAIN;
                            end
                        end else if (in_last) begin
                            frame_err <= 1'b1;
                            cnt       <= '0;
                        end else begin
                            cnt <= cnt + 5'd1;
                        end
                    end
                end
                DRAIN: begin
                    if (fire && in_last) begin
                        state <= LOAD;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    if (done_single) begin
                        active_single <= 1'b0;
                        frames_done   <= frames_done + 8'd1;
                        state         <= LOAD;
`ifdef LOADER_TIMEOUT_EN
                    end else if (tmr == '0) begin
                        active_single <= 1'b0;
                        frame_err     <= 1'b1;
                        state         <= LOAD;
                    end else begin
                        tmr <= tmr - 1'b1;
`endif
                    end
                end
                default: begin
                    state         <= LOAD;
                    cnt           <= '0;
                    active_single <= 1'b0;
                end
            endcase
        end
    end

    assign a11 = ops[0];   assign a12 = ops[1];   assign a13 = ops[2];   assign a14 = ops[3];
    assign a21 = ops[4];   assign a22 = ops[5];   assign a23 = ops[6];   assign a24 = ops[7];
    assign a31 = ops[8];   assign a32 = ops[9];   assign a33 = ops[10];  assign a34 = ops[11];
    assign a41 = ops[12];  assign a42 = ops[13];  assign a43 = ops[14];  assign a44 = ops[15];
    assign b11 = ops[16];  assign b12 = ops[17];  assign b13 = ops[18];
    assign b21 = ops[19];  assign b22 = ops[20];  assign b23 = ops[21];
    assign b31 = ops[22];  assign b32 = ops[23];  assign b33 = ops[24];

endmodule

// File: tb/tb_conv_operand_loader.sv
// Directed bench for conv_operand_loader; define LOADER_TIMEOUT_EN to exercise the watchdog (TIMEOUT_CYCLES=8).
module tb_conv_operand_loader;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_last;
    logic       done_single;
    logic [7:0] in_data;
    logic       in_ready;
    logic       active_single;
    logic       frame_err;
    logic [7:0] frames_done;
    logic [7:0] ops [25];

    int errors = 0;
    int checks = 0;
    int early;

    always #5 clk = ~clk;

    conv_operand_loader #(.DATA_W(8), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .done_single(done_single), .active_single(active_single),
        .a11(ops[0]),  .a12(ops[1]),  .a13(ops[2]),  .a14(ops[3]),
        .a21(ops[4]),  .a22(ops[5]),  .a23(ops[6]),  .a24(ops[7]),
        .a31(ops[8]),  .a32(ops[9]),  .a33(ops[10]), .a34(ops[11]),
        .a41(ops[12]), .a42(ops[13]), .a43(ops[14]), .a44(ops[15]),
        .b11(ops[16]), .b12(ops[17]), .b13(ops[18]),
        .b21(ops[19]), .b22(ops[20]), .b23(ops[21]),
        .b31(ops[22]), .b32(ops[23]), .b33(ops[24]),
        .frame_err(frame_err), .frames_done(frames_done)
    );

    // Drives one beat from just after an edge; it transfers on the next rising edge.
    task automatic beat(input logic [7:0] d, input logic l);
        in_valid = 1'b1; in_data = d; in_last = l;
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic send_frame(input int base, input int n, input int last_at, input bit gap, output int early_cnt);
        early_cnt = 0;
        for (int k = 0; k < n; k++) begin
            beat(8'(base + k + 1), k == last_at);
            if (k != n - 1 && active_single) early_cnt++;
            if (gap && k != n - 1) begin
                @(posedge clk); #1;
                if (active_single) early_cnt++;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0; done_single = 1'b0;
        #3;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %0b want 0", in_ready); end
        checks++; if (active_single !== 1'b0) begin errors++; $display("FAIL reset_active: got %0b want 0", active_single); end
        checks++; if (frames_done !== 8'd0) begin errors++; $display("FAIL reset_frames_done: got %0d want 0", frames_done); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %0b want 0", frame_err); end
        checks++; if (ops[0] !== 8'd0 || ops[24] !== 8'd0) begin errors++; $display("FAIL reset_operands: got a11=%0d b33=%0d want 0", ops[0], ops[24]); end
        #19 rst = 1'b1;
        @(posedge clk); #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready: got %0b want 1", in_ready); end
    endtask

    task automatic test_basic();
        send_frame(0, 25, 24, 1'b0, early);
        checks++; if (early !== 0) begin errors++; $display("FAIL basic_early_launch: got %0d want 0", early); end
        checks++; if (active_single !== 1'b1) begin errors++; $display("FAIL basic_launch: got %0b want 1", active_single); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL basic_run_ready: got %0b want 0", in_ready); end
        checks++; if (ops[0] !== 8'd1) begin errors++; $display("FAIL basic_a11: got %0d want 1", ops[0]); end
        checks++; if (ops[3] !== 8'd4) begin errors++; $display("FAIL basic_a14: got %0d want 4", ops[3]); end
        checks++; if (ops[15] !== 8'd16) begin errors++; $display("FAIL basic_a44: got %0d want 16", ops[15]); end
        checks++; if (ops[16] !== 8'd17) begin errors++; $display("FAIL basic_b11: got %0d want 17", ops[16]); end
        checks++; if (ops[24] !== 8'd25) begin errors++; $display("FAIL basic_b33: got %0d want 25", ops[24]); end
        repeat (4) begin @(posedge clk); #1; end
        checks++; if (active_single !== 1'b1) begin errors++; $display("FAIL basic_hold: got %0b want 1", active_single); end
        done_single = 1'b1;
        @(posedge clk); #1;
        done_single = 1'b0;
        checks++; if (active_single !== 1'b0) begin errors++; $display("FAIL basic_done_drop: got %0b want 0", active_single); end
        checks++; if (frames_done !== 8'd1) begin errors++; $display("FAIL basic_frames_done: got %0d want 1", frames_done); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL basic_rearm_ready: got %0b want 1", in_ready); end
    endtask

    task automatic test_toggle();
        send_frame(50, 25, 24, 1'b1, early);
        checks++; if (early !== 0) begin errors++; $display("FAIL toggle_early_launch: got %0d want 0", early); end
        checks++; if (active_single !== 1'b1) begin errors++; $display("FAIL toggle_launch: got %0b want 1", active_single); end
        for (int k = 0; k < 25; k++) begin
            checks++;
            if (ops[k] !== 8'(51 + k)) begin errors++; $display("FAIL toggle_operand[%0d]: got %0d want %0d", k, ops[k], 51 + k); end
        end
        // done in the very cycle active rises gives a one-cycle pulse
        done_single = 1'b1;
        @(posedge clk); #1;
        done_single = 1'b0;
        checks++; if (active_single !== 1'b0) begin errors++; $display("FAIL toggle_one_cycle_pulse: got %0b want 0", active_single); end
        checks++; if (frames_done !== 8'd2) begin errors++; $display("FAIL toggle_frames_done: got %0d want 2", frames_done); end
    endtask

    task automatic test_short_frame();
        send_frame(200, 10, 9, 1'b0, early);
        repeat (2) begin @(posedge clk); #1; end
        checks++; if (early !== 0 || active_single !== 1'b0) begin errors++; $display("FAIL short_no_launch: got early=%0d active=%0b want 0 0", early, active_single); end
        checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL short_frame_err: got %0b want 1", frame_err); end
        checks++; if (ops[0] !== 8'd201) begin errors++; $display("FAIL short_a11: got %0d want 201", ops[0]); end
        checks++; if (ops[9] !== 8'd210) begin errors++; $display("FAIL short_a32: got %0d want 210", ops[9]); end
        checks++; if (ops[10] !== 8'd61) begin errors++; $display("FAIL short_a33_kept: got %0d want 61", ops[10]); end
        send_frame(100, 25, 24, 1'b0, early);
        checks++; if (active_single !== 1'b1) begin errors++; $display("FAIL short_next_launch: got %0b want 1", active_single); end
        checks++; if (ops[0] !== 8'd101 || ops[24] !== 8'd125) begin errors++; $display("FAIL short_next_operands: got a11=%0d b33=%0d want 101 125", ops[0], ops[24]); end
        done_single = 1'b1;
        @(posedge clk); #1;
        done_single = 1'b0;
        checks++; if (frames_done !== 8'd3) begin errors++; $display("FAIL short_frames_done: got %0d want 3", frames_done); end
    endtask

    task automatic test_no_last();
        rst = 1'b0;
        #4;
        checks++; if (frame_err !== 1'b0 || frames_done !== 8'd0) begin errors++; $display("FAIL nolast_reset: got err=%0b frames=%0d want 0 0", frame_err, frames_done); end
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        send_frame(150, 25, -1, 1'b0, early);
        checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL nolast_frame_err: got %0b want 1", frame_err); end
        checks++; if (active_single !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL nolast_drain: got active=%0b ready=%0b want 0 1", active_single, in_ready); end
        send_frame(0, 3, 2, 1'b0, early);
        checks++; if (active_single !== 1'b0) begin errors++; $display("FAIL nolast_no_launch: got %0b want 0", active_single); end
        checks++; if (ops[0] !== 8'd151 || ops[2] !== 8'd153 || ops[24] !== 8'd175) begin
            errors++; $display("FAIL nolast_operands_kept: got a11=%0d a13=%0d b33=%0d want 151 153 175", ops[0], ops[2], ops[24]);
        end
        send_frame(0, 25, 24, 1'b0, early);
        checks++; if (active_single !== 1'b1 || ops[2] !== 8'd3) begin errors++; $display("FAIL nolast_next_launch: got active=%0b a13=%0d want 1 3", active_single, ops[2]); end
        done_single = 1'b1;
        @(posedge clk); #1;
        done_single = 1'b0;
        checks++; if (frames_done !== 8'd1) begin errors++; $display("FAIL nolast_frames_done: got %0d want 1", frames_done); end
    endtask

    task automatic test_done_in_load_and_reset();
        done_single = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        done_single = 1'b0;
        checks++; if (frames_done !== 8'd1 || active_single !== 1'b0) begin errors++; $display("FAIL load_done_ignored: got frames=%0d active=%0b want 1 0", frames_done, active_single); end
        send_frame(30, 25, 24, 1'b0, early);
        checks++; if (active_single !== 1'b1) begin errors++; $display("FAIL midrun_launch: got %0b want 1", active_single); end
        #2 rst = 1'b0;
        #1;
        checks++; if (active_single !== 1'b0) begin errors++; $display("FAIL midrun_reset_active: got %0b want 0", active_single); end
        checks++; if (ops[0] !== 8'd0 || ops[24] !== 8'd0) begin errors++; $display("FAIL midrun_reset_operands: got a11=%0d b33=%0d want 0", ops[0], ops[24]); end
        checks++; if (frames_done !== 8'd0 || in_ready !== 1'b0) begin errors++; $display("FAIL midrun_reset_state: got frames=%0d ready=%0b want 0 0", frames_done, in_ready); end
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        checks++; if (in_ready !== 1'b1 || active_single !== 1'b0) begin errors++; $display("FAIL midrun_release: got ready=%0b active=%0b want 1 0", in_ready, active_single); end
    endtask

    task automatic test_timeout();
        int n;
        send_frame(70, 25, 24, 1'b0, early);
        checks++; if (active_single !== 1'b1) begin errors++; $display("FAIL timeout_launch: got %0b want 1", active_single); end
`ifdef LOADER_TIMEOUT_EN
        n = 0;
        while (active_single && n < 100) begin
            n++;
            @(posedge clk); #1;
        end
        checks++; if (n !== 8) begin errors++; $display("FAIL timeout_run_cycles: got %0d want 8", n); end
        checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL timeout_frame_err: got %0b want 1", frame_err); end
        checks++; if (frames_done !== 8'd0 || in_ready !== 1'b1) begin errors++; $display("FAIL timeout_state: got frames=%0d ready=%0b want 0 1", frames_done, in_ready); end
`else
        n = 20;
        repeat (n) begin @(posedge clk); #1; end
        checks++; if (active_single !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL no_watchdog_hold: got active=%0b ready=%0b want 1 0", active_single, in_ready); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL no_watchdog_err: got %0b want 0", frame_err); end
        done_single = 1'b1;
        @(posedge clk); #1;
        done_single = 1'b0;
        checks++; if (frames_done !== 8'd1 || active_single !== 1'b0) begin errors++; $display("FAIL no_watchdog_done: got frames=%0d active=%0b want 1 0", frames_done, active_single); end
`endif
    endtask

    initial begin
        test_reset();
        test_basic();
        test_toggle();
        test_short_frame();
        test_no_last();
        test_done_in_load_and_reset();
        test_timeout();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
